matrix_tx_formatter: RTL and testbench



---
 rtl/matrix_tx_formatter_pkg.sv | 40 ++++
 rtl/matrix_tx_formatter_if.sv | 30 +++
 rtl/matrix_tx_formatter_dec_split.sv | 21 ++
 rtl/matrix_tx_formatter.sv | 170 +++++++++++++++++
 tb/tb_matrix_tx_formatter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/matrix_tx_formatter_pkg.sv
// rtl/matrix_tx_formatter_pkg.sv - shared types and constants for the matrix TX formatter
package matrix_tx_formatter_pkg;

  localparam int DATA_W       = 8;
  localparam int FIELD_W      = 4;
  localparam int SUM_FIELD_W  = 3;
  localparam int BUF_DEPTH    = 32;
  localparam int PTR_W        = $clog2(BUF_DEPTH);
  localparam int HEAD_STR_LEN = 15;
  localparam int TOTAL_STR_LEN = 7;

  typedef logic signed [DATA_W-1:0] matrix_element_t;

  typedef enum logic [2:0] {FMT_NL, FMT_HEAD, FMT_SUM, FMT_ID, FMT_PLAIN} fmt_mode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_BUILD, ST_EMIT, ST_DONE} fmt_state_t;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_BAR   = 8'h7C;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam logic [8*HEAD_STR_LEN-1:0]  HEAD_STR  = "| M | N | CNT |";
  localparam logic [8*TOTAL_STR_LEN-1:0] TOTAL_STR = "Total: ";

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

  function automatic fmt_mode_t pick_mode(input logic nl, input logic head,
                                          input logic sum, input logic id);
    if (nl)        return FMT_NL;
    else if (head) return FMT_HEAD;
    else if (sum)  return FMT_SUM;
    else if (id)   return FMT_ID;
    else           return FMT_PLAIN;
  endfunction

endpackage

// File: rtl/matrix_tx_formatter_if.sv
// rtl/matrix_tx_formatter_if.sv - print command and UART byte handshake bundle
interface matrix_tx_formatter_if;
  import matrix_tx_formatter_pkg::*;

  matrix_element_t in_data;
  logic            in_start;
  logic            in_is_last_col;
  logic            in_newline_only;
  logic            in_id;
  logic            in_sum_head;
  logic            in_sum_elem;
  logic            in_ready;
  logic            in_done;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;

  modport master (
    output in_data, in_start, in_is_last_col, in_newline_only, in_id,
           in_sum_head, in_sum_elem, tx_ready,
    input  in_ready, in_done, tx_data, tx_valid
  );

  modport slave (
    input  in_data, in_start, in_is_last_col, in_newline_only, in_id,
           in_sum_head, in_sum_elem, tx_ready,
    output in_ready, in_done, tx_data, tx_valid
  );

endinterface

// File: rtl/matrix_tx_formatter_dec_split.sv
// rtl/matrix_tx_formatter_dec_split.sv - splits an unsigned magnitude into decimal digits
module dec_split #(
  parameter int MAG_W = 9
) (
  input  logic [MAG_W-1:0] mag,
  output logic [3:0]       hun,
  output logic [3:0]       ten,
  output logic [3:0]       one,
  output logic [1:0]       ndigits
);

  always_comb begin
    hun = 4'(mag / MAG_W'(100));
    ten = 4'((mag % MAG_W'(100)) / MAG_W'(10));
    one = 4'(mag % MAG_W'(10));
    if (hun != 4'd0)      ndigits = 2'd3;
    else if (ten != 4'd0) ndigits = 2'd2;
    else                  ndigits = 2'd1;
  end

endmodule

// File: rtl/matrix_tx_formatter.sv
// rtl/matrix_tx_formatter.sv - renders one print command to ASCII and drains it to the UART
module matrix_tx_formatter
  import matrix_tx_formatter_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  matrix_tx_formatter_if.slave bus
);

  fmt_state_t       state;
  fmt_mode_t        mode_q;
  matrix_element_t  data_q;
  logic             last_q;
  logic [7:0]       line_buf [BUF_DEPTH];
  logic [PTR_W-1:0] len;
  logic [PTR_W-1:0] rd_ptr;
  logic             ready_q;
  logic             done_q;
  logic             valid_q;
  logic [7:0]       data_out_q;

  logic             neg;
  logic [DATA_W:0]  ext;
  logic [DATA_W:0]  mag;
  logic [3:0]       d_hun, d_ten, d_one;
  logic [1:0]       nd;
  logic [7:0]       dchar [3];
  logic [7:0]       rbuf [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  int               pad;

  dec_split #(.MAG_W(DATA_W + 1)) u_dec_split (
    .mag     (mag),
    .hun     (d_hun),
    .ten     (d_ten),
    .one     (d_one),
    .ndigits (nd)
  );

  // One bit wider than the data so that the most negative value keeps its magnitude
  always_comb begin
    neg = data_q[DATA_W-1];
    ext = {data_q[DATA_W-1], data_q};
    mag = neg ? -ext : ext;
    case (nd)
      2'd3:    begin dchar[0] = digit_char(d_hun); dchar[1] = digit_char(d_ten); dchar[2] = digit_char(d_one); end
      2'd2:    begin dchar[0] = digit_char(d_ten); dchar[1] = digit_char(d_one); dchar[2] = ASCII_SP; end
      default: begin dchar[0] = digit_char(d_one); dchar[1] = ASCII_SP;          dchar[2] = ASCII_SP; end
    endcase
  end

  // Buffer defaults to spaces, so padding is just advancing the write pointer
  always_comb begin
    for (int i = 0; i < BUF_DEPTH; i++) rbuf[i] = ASCII_SP;
    wr_ptr = '0;
    pad    = 0;
    case (mode_q)
      FMT_HEAD: begin
        for (int k = 0; k < TOTAL_STR_LEN; k++) begin
          rbuf[wr_ptr] = TOTAL_STR[8*(TOTAL_STR_LEN-1-k) +: 8];
          wr_ptr = wr_ptr + PTR_W'(1);
        end
      end
      FMT_SUM: begin
        rbuf[wr_ptr] = ASCII_BAR;
        pad    = SUM_FIELD_W - int'(nd);
        wr_ptr = wr_ptr + PTR_W'(2) + PTR_W'(pad);
      end
      FMT_PLAIN: begin
        pad    = FIELD_W - int'(nd) - (neg ? 1 : 0);
        wr_ptr = wr_ptr + PTR_W'(pad);
        if (neg) begin
          rbuf[wr_ptr] = ASCII_MINUS;
          wr_ptr = wr_ptr + PTR_W'(1);
        end
      end
      default: ;
    endcase
    if (mode_q != FMT_NL) begin
      for (int k = 0; k < 3; k++) begin
        if (k < int'(nd)) begin
          rbuf[wr_ptr] = dchar[k];
          wr_ptr = wr_ptr + PTR_W'(1);
        end
      end
    end
    if (mode_q == FMT_HEAD) begin
      rbuf[wr_ptr] = ASCII_CR;
      rbuf[wr_ptr + PTR_W'(1)] = ASCII_LF;
      wr_ptr = wr_ptr + PTR_W'(2);
      for (int k = 0; k < HEAD_STR_LEN; k++) begin
        rbuf[wr_ptr] = HEAD_STR[8*(HEAD_STR_LEN-1-k) +: 8];
        wr_ptr = wr_ptr + PTR_W'(1);
      end
    end else if (mode_q == FMT_SUM) begin
      wr_ptr = wr_ptr + PTR_W'(1);
      if (last_q) begin
        rbuf[wr_ptr] = ASCII_BAR;
        wr_ptr = wr_ptr + PTR_W'(1);
      end
    end
    if (mode_q == FMT_NL || mode_q == FMT_HEAD || last_q) begin
      rbuf[wr_ptr] = ASCII_CR;
      rbuf[wr_ptr + PTR_W'(1)] = ASCII_LF;
      wr_ptr = wr_ptr + PTR_W'(2);
    end else if (mode_q != FMT_SUM) begin
      wr_ptr = wr_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mode_q     <= FMT_PLAIN;
      data_q     <= '0;
      last_q     <= 1'b0;
      len        <= '0;
      rd_ptr     <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_out_q <= 8'h00;
      for (int i = 0; i < BUF_DEPTH; i++) line_buf[i] <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_start) begin
            data_q  <= bus.in_data;
            last_q  <= bus.in_is_last_col;
            mode_q  <= pick_mode(bus.in_newline_only, bus.in_sum_head,
                                 bus.in_sum_elem, bus.in_id);
            ready_q <= 1'b0;
            state   <= ST_BUILD;
          end
        end
        ST_BUILD: begin
          line_buf   <= rbuf;
          len        <= wr_ptr;
          rd_ptr     <= '0;
          data_out_q <= rbuf[0];
          valid_q    <= 1'b1;
          state      <= ST_EMIT;
        end
        ST_EMIT: begin
          if (bus.tx_ready) begin
            if (rd_ptr == len - PTR_W'(1)) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state   <= ST_DONE;
            end else begin
              rd_ptr     <= rd_ptr + PTR_W'(1);
              data_out_q <= line_buf[rd_ptr + PTR_W'(1)];
            end
          end
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.in_done  = done_q;
  assign bus.tx_valid = valid_q;
  assign bus.tx_data  = data_out_q;

endmodule

// File: tb/tb_matrix_tx_formatter.sv
// tb/tb_matrix_tx_formatter.sv - randomized self-checking bench for matrix_tx_formatter
module tb_matrix_tx_formatter;
  import matrix_tx_formatter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  matrix_tx_formatter_if bus ();

  matrix_tx_formatter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int           n_cmp = 0;
  int           n_err = 0;
  byte unsigned exp_q[$];
  bit           ready_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic string pad_left(input string s, input int w);
    string r = s;
    while (r.len() < w) r = {" ", r};
    return r;
  endfunction

  // Expected text straight from the print rules, built as strings
  function automatic string render_ref(input int v, input bit last, input bit nl,
                                       input bit head, input bit sum, input bit id);
    int    mag = (v < 0) ? -v : v;
    string s;
    if (nl) return "\r\n";
    if (head) return $sformatf("Total: %0d\r\n| M | N | CNT |\r\n", mag);
    if (sum) begin
      s = {"| ", pad_left($sformatf("%0d", mag), 3), " "};
      if (last) s = {s, "|\r\n"};
      return s;
    end
    if (id) s = $sformatf("%0d", mag);
    else    s = pad_left($sformatf("%0d", v), 4);
    if (last) s = {s, "\r\n"};
    else      s = {s, " "};
    return s;
  endfunction

  task automatic scramble_inputs();
    bus.in_data         = 8'($urandom);
    bus.in_is_last_col  = 1'($urandom);
    bus.in_newline_only = 1'($urandom);
    bus.in_id           = 1'($urandom);
    bus.in_sum_head     = 1'($urandom);
    bus.in_sum_elem     = 1'($urandom);
  endtask

  // ready_mode: 0 always ready, 1 random, 2 pop ready_q then ready
  task automatic send_cmd(input int v, input bit last, input bit nl, input bit head,
                          input bit sum, input bit id, input int ready_mode,
                          input bit mid_start, input int abort_at);
    string s;
    int    idx;
    int    cyc;
    bit    r;
    s = render_ref(v, last, nl, head, sum, id);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("ready_before", bus.in_ready, 1);
    bus.in_data         = 8'(v);
    bus.in_is_last_col  = last;
    bus.in_newline_only = nl;
    bus.in_sum_head     = head;
    bus.in_sum_elem     = sum;
    bus.in_id           = id;
    bus.in_start        = 1'b1;
    @(negedge clk);
    bus.in_start = 1'b0;
    scramble_inputs();
    check_eq("ready_drop", bus.in_ready, 0);
    check_eq("valid_build", bus.tx_valid, 0);
    @(negedge clk);
    idx = 0;
    cyc = 0;
    while (idx < exp_q.size() && cyc < 2000) begin
      if (abort_at >= 0 && idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", bus.tx_valid, 0);
        check_eq("rst_ready", bus.in_ready, 1);
        check_eq("rst_done", bus.in_done, 0);
        check_eq("rst_data", bus.tx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.tx_ready = 1'b1;
        @(negedge clk);
        check_eq("post_rst_done", bus.in_done, 0);
        return;
      end
      check_eq($sformatf("valid[%0d]", idx), bus.tx_valid, 1);
      check_eq($sformatf("data[%0d]", idx), bus.tx_data, exp_q[idx]);
      check_eq("done_early", bus.in_done, 0);
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (ready_q.size() > 0) ? ready_q.pop_front() : 1'b1;
      endcase
      bus.tx_ready = r;
      bus.in_start = mid_start && (cyc == 1);
      @(negedge clk);
      bus.in_start = 1'b0;
      cyc++;
      if (r) idx++;
    end
    check_eq("byte_count", idx, exp_q.size());
    check_eq("done_pulse", bus.in_done, 1);
    check_eq("valid_after", bus.tx_valid, 0);
    @(negedge clk);
    check_eq("done_clear", bus.in_done, 0);
    check_eq("ready_back", bus.in_ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n               = 1'b0;
    bus.in_start        = 1'b0;
    bus.in_data         = '0;
    bus.in_is_last_col  = 1'b0;
    bus.in_newline_only = 1'b0;
    bus.in_id           = 1'b0;
    bus.in_sum_head     = 1'b0;
    bus.in_sum_elem     = 1'b0;
    bus.tx_ready        = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_ready", bus.in_ready, 1);
    check_eq("reset_done", bus.in_done, 0);
    check_eq("reset_valid", bus.tx_valid, 0);
    check_eq("reset_data", bus.tx_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send_cmd(-5,   0, 0, 0, 0, 0, 0, 0, -1);
    send_cmd(-128, 1, 0, 0, 0, 0, 0, 0, -1);
    send_cmd(0,    0, 0, 0, 0, 0, 0, 0, -1);
    send_cmd(12,   0, 0, 1, 0, 0, 1, 0, -1);
    send_cmd(3,    0, 0, 0, 1, 0, 0, 1, -1);
    send_cmd(4,    0, 0, 0, 1, 0, 1, 1, -1);
    send_cmd(2,    1, 0, 0, 1, 0, 0, 1, -1);
    ready_q = '{1'b1, 1'b0, 1'b0, 1'b1};
    send_cmd(7,    1, 0, 0, 0, 1, 2, 0, -1);
    send_cmd(9,    0, 1, 0, 1, 0, 0, 0, -1);
    send_cmd(99,   0, 0, 1, 0, 0, 0, 0, 5);
    send_cmd(-42,  1, 0, 0, 0, 0, 1, 0, -1);
    send_cmd(127,  0, 0, 0, 0, 1, 0, 0, -1);
    send_cmd(-128, 1, 0, 0, 1, 0, 0, 0, -1);
    send_cmd(-100, 1, 0, 1, 0, 0, 1, 0, -1);

    for (int t = 0; t < 60; t++) begin
      send_cmd(int'($urandom_range(0, 255)) - 128,
               1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 1)), 1'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
